// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: store-buffer drain versus 16-word line fill.
// Define MEM_ARB_RAW_CHECK_EN to drain buffered stores that hit the requested block before filling it.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  fill_ack,
  output logic [WORD_WIDTH-1:0] fill_data,
  output logic                  fill_data_valid,
  output logic                  fill_done,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [WORD_WIDTH-1:0] st_data,
  output logic                  st_ready,
  output logic                  wbuf_empty,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic                  memory_write_en,
  output logic [WORD_WIDTH-1:0] memory_write_data,
  output logic                  memory_read_addr_valid,
  input  logic                  memory_read_ready,
  input  logic                  memory_read_valid,
  input  logic [WORD_WIDTH-1:0] memory_read_data
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int BLK_W = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FILL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q [WBUF_DEPTH];
  logic [ADDR_WIDTH-1:0] wb_addr_d [WBUF_DEPTH];
  logic [WORD_WIDTH-1:0] wb_data_q [WBUF_DEPTH];
  logic [WORD_WIDTH-1:0] wb_data_d [WBUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic [4:0]            issue_cnt_q, issue_cnt_d;
  logic [3:0]            ret_cnt_q, ret_cnt_d;

  logic                  fill_ack_q, fill_ack_d;
  logic [WORD_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                  fill_data_valid_q, fill_data_valid_d;
  logic                  fill_done_q, fill_done_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_rav_q, mem_rav_d;

  logic push, pop, full, fill_wins;

  // Word offset of the fill address is meaningless; fills always cover the whole block.
  logic unused_fill_lsb;
  assign unused_fill_lsb = ^fill_addr[3:0];

  assign full       = (count_q == (PTR_W+1)'(WBUF_DEPTH));
  assign st_ready   = !full;
  assign wbuf_empty = (count_q == '0);
  assign push       = st_valid & st_ready;

`ifdef MEM_ARB_RAW_CHECK_EN
  logic raw_hit;

  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) &&
          (wb_addr_q[i][ADDR_WIDTH-1:4] == fill_addr[ADDR_WIDTH-1:4]))
        raw_hit = 1'b1;
    end
  end

  assign fill_wins = fill_req & !raw_hit;
`else
  assign fill_wins = fill_req;
`endif

  always_comb begin
    state_d           = state_q;
    wb_addr_d         = wb_addr_q;
    wb_data_d         = wb_data_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    blk_d             = blk_q;
    issue_cnt_d       = issue_cnt_q;
    ret_cnt_d         = ret_cnt_q;
    fill_ack_d        = 1'b0;
    fill_data_d       = fill_data_q;
    fill_data_valid_d = 1'b0;
    fill_done_d       = 1'b0;
    mem_addr_d        = mem_addr_q;
    mem_we_d          = 1'b0;
    mem_wdata_d       = mem_wdata_q;
    mem_rav_d         = 1'b0;
    pop               = 1'b0;

    if (push) begin
      wb_addr_d[wr_ptr_q] = st_addr;
      wb_data_d[wr_ptr_q] = st_data;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fill_wins) begin
          state_d     = ST_FILL;
          fill_ack_d  = 1'b1;
          blk_d       = fill_addr[ADDR_WIDTH-1:4];
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end else if (count_q != '0) begin
          // Head is popped on the decision edge so the write appears one cycle after arbitration.
          state_d     = ST_DRAIN;
          pop         = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr_q[rd_ptr_q];
          mem_wdata_d = wb_data_q[rd_ptr_q];
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      ST_FILL: begin
        if (!issue_cnt_q[4] && memory_read_ready) begin
          mem_rav_d   = 1'b1;
          mem_addr_d  = {blk_q, issue_cnt_q[3:0]};
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (memory_read_valid) begin
          fill_data_d       = memory_read_data;
          fill_data_valid_d = 1'b1;
          ret_cnt_d         = ret_cnt_q + 1'b1;
          if (ret_cnt_q == 4'd15) begin
            fill_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= ST_IDLE;
      for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      blk_q             <= '0;
      issue_cnt_q       <= '0;
      ret_cnt_q         <= '0;
      fill_ack_q        <= 1'b0;
      fill_data_q       <= '0;
      fill_data_valid_q <= 1'b0;
      fill_done_q       <= 1'b0;
      mem_addr_q        <= '0;
      mem_we_q          <= 1'b0;
      mem_wdata_q       <= '0;
      mem_rav_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      wb_addr_q         <= wb_addr_d;
      wb_data_q         <= wb_data_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      blk_q             <= blk_d;
      issue_cnt_q       <= issue_cnt_d;
      ret_cnt_q         <= ret_cnt_d;
      fill_ack_q        <= fill_ack_d;
      fill_data_q       <= fill_data_d;
      fill_data_valid_q <= fill_data_valid_d;
      fill_done_q       <= fill_done_d;
      mem_addr_q        <= mem_addr_d;
      mem_we_q          <= mem_we_d;
      mem_wdata_q       <= mem_wdata_d;
      mem_rav_q         <= mem_rav_d;
    end
  end

  assign fill_ack               = fill_ack_q;
  assign fill_data              = fill_data_q;
  assign fill_data_valid        = fill_data_valid_q;
  assign fill_done              = fill_done_q;
  assign memory_addr            = mem_addr_q;
  assign memory_write_en        = mem_we_q;
  assign memory_write_data      = mem_wdata_q;
  assign memory_read_addr_valid = mem_rav_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected writes, read addresses and fill words are
// queued as stimulus is driven and popped as the DUT presents them.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_req;
  logic [AW-1:0] fill_addr;
  logic          fill_ack;
  logic [WW-1:0] fill_data;
  logic          fill_data_valid;
  logic          fill_done;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [WW-1:0] st_data;
  logic          st_ready;
  logic          wbuf_empty;
  logic [AW-1:0] memory_addr;
  logic          memory_write_en;
  logic [WW-1:0] memory_write_data;
  logic          memory_read_addr_valid;
  logic          memory_read_ready;
  logic          memory_read_valid;
  logic [WW-1:0] memory_read_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WBUF_DEPTH(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fill_req               (fill_req),
    .fill_addr              (fill_addr),
    .fill_ack               (fill_ack),
    .fill_data              (fill_data),
    .fill_data_valid        (fill_data_valid),
    .fill_done              (fill_done),
    .st_valid               (st_valid),
    .st_addr                (st_addr),
    .st_data                (st_data),
    .st_ready               (st_ready),
    .wbuf_empty             (wbuf_empty),
    .memory_addr            (memory_addr),
    .memory_write_en        (memory_write_en),
    .memory_write_data      (memory_write_data),
    .memory_read_addr_valid (memory_read_addr_valid),
    .memory_read_ready      (memory_read_ready),
    .memory_read_valid      (memory_read_valid),
    .memory_read_data       (memory_read_data)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_wr [$];
  logic [31:0] exp_ra [$];
  logic [31:0] exp_fd [$];
  logic [31:0] mem_pend [$];

  int cyc = 0;
  int ret_seen = 0;
  int fill_done_cnt = 0;
  int wr_last = -1;
  int rd_first = -1;
  bit fill_active = 1'b0;
  bit toggle_mode = 1'b0;
  bit spurious = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5A5_0000) + 32'h0000_1111;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus memory model; inputs change here, away from the sampling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    logic        rdy_sampled;
    rdy_sampled = memory_read_ready;
    if (rst) begin
      if (memory_write_en) begin
        check_eq("we_not_in_fill", fill_active, 0);
        check_eq("we_rav_exclusive", memory_read_addr_valid, 0);
        wr_last = cyc;
        if (exp_wr.size() == 0) check_eq("wr_extra", 1, 0);
        else begin
          e = exp_wr.pop_front();
          check_eq("wr_addr", memory_addr, e[63:32]);
          check_eq("wr_data", memory_write_data, e[31:0]);
        end
      end
      if (memory_read_addr_valid) begin
        check_eq("rd_on_ready", rdy_sampled, 1);
        if (rd_first < 0) rd_first = cyc;
        if (exp_ra.size() == 0) check_eq("rd_extra", 1, 0);
        else check_eq("rd_addr", memory_addr, exp_ra.pop_front());
        mem_pend.push_back(memory_addr);
      end
      if (fill_ack) fill_active = 1'b1;
      if (fill_data_valid) begin
        ret_seen++;
        if (exp_fd.size() == 0) check_eq("fd_extra", 1, 0);
        else check_eq("fill_data", fill_data, exp_fd.pop_front());
      end
      if (fill_done) begin
        check_eq("done_at_16", ret_seen, 16);
        check_eq("done_with_valid", fill_data_valid, 1);
        fill_done_cnt++;
        fill_active = 1'b0;
        ret_seen = 0;
      end
      memory_read_ready = toggle_mode ? ~memory_read_ready : 1'b1;
      if (spurious) begin
        memory_read_valid = 1'b1;
        memory_read_data  = 32'hBAD0_BAD0;
        spurious = 1'b0;
      end else if (mem_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        memory_read_valid = 1'b1;
        memory_read_data  = mem_word(mem_pend.pop_front());
      end else begin
        memory_read_valid = 1'b0;
      end
    end else begin
      memory_read_valid = 1'b0;
      mem_pend.delete();
    end
  end

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (st_ready) begin
        exp_wr.push_back({a, d});
        ok = 1'b1;
      end
      @(negedge clk);
    end
    st_valid = 1'b0;
    check_eq("st_accept", ok, 1);
  endtask

  task automatic do_fill(input logic [31:0] a);
    bit acked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_ra.push_back({a[31:4], 4'(i)});
      exp_fd.push_back(mem_word({a[31:4], 4'(i)}));
    end
    fill_req  = 1'b1;
    fill_addr = a;
    for (int i = 0; i < 50 && !acked; i++) begin
      @(negedge clk);
      if (fill_ack) acked = 1'b1;
    end
    fill_req = 1'b0;
    check_eq("fill_ack_seen", acked, 1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && fill_done_cnt < n; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("fill_done_cnt", fill_done_cnt, n);
    check_eq("all_addrs_issued", exp_ra.size(), 0);
    check_eq("all_words_returned", exp_fd.size(), 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && !(wbuf_empty && exp_wr.size() == 0); i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("drained_empty", wbuf_empty, 1);
    check_eq("drained_queue", exp_wr.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_flags"},
             {fill_ack, fill_data_valid, fill_done, memory_write_en,
              memory_read_addr_valid, wbuf_empty, st_ready}, 7'b0000011);
    check_eq({tag, "_maddr"}, memory_addr, 0);
    check_eq({tag, "_wdata"}, memory_write_data, 0);
    check_eq({tag, "_fdata"}, fill_data, 0);
  endtask

  initial begin
    rst = 1'b0;
    fill_req = 1'b0; fill_addr = '0;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    memory_read_ready = 1'b1; memory_read_valid = 1'b0; memory_read_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    // Single store in IDLE: write appears the cycle after the arbitration edge.
    push_store(32'h100, 32'hDEAD_BEEF);
    check_eq("t1_no_we_yet", memory_write_en, 0);
    @(negedge clk);
    check_eq("t1_we", memory_write_en, 1);
    check_eq("t1_addr", memory_addr, 32'h100);
    check_eq("t1_data", memory_write_data, 32'hDEAD_BEEF);
    check_eq("t1_empty", wbuf_empty, 1);
    @(negedge clk);
    check_eq("t1_we_one_cycle", memory_write_en, 0);

    // Full-rate fill; word offset in the request is ignored.
    do_fill(32'h0000_024C);
    wait_done(1);

    // Ready toggling each cycle.
    toggle_mode = 1'b1;
    do_fill(32'h0000_1230);
    wait_done(2);

    // Five stores while a fill holds the port.
    do_fill(32'h0000_0500);
    for (int i = 0; i < 4; i++) push_store(32'h600 + i, 32'hC0DE_0000 + i);
    check_eq("t4_full_after_4", st_ready, 0);
    check_eq("t4_not_empty", wbuf_empty, 0);
    push_store(32'h604, 32'hC0DE_0004);
    check_eq("t4_fifth_after_done", fill_done_cnt, 3);
    toggle_mode = 1'b0;
    wait_done(3);
    wait_drain();
    repeat (3) @(negedge clk);

    // Buffered store in the requested block versus fill priority.
    wr_last = -1;
    rd_first = -1;
    push_store(32'h243, 32'h0BAD_F00D);
    do_fill(32'h0000_0240);
    wait_done(4);
    wait_drain();
`ifdef MEM_ARB_RAW_CHECK_EN
    check_eq("raw_write_first", (wr_last >= 0 && wr_last < rd_first), 1);
`else
    check_eq("raw_read_first", (rd_first >= 0 && rd_first < wr_last), 1);
`endif

    // Read-valid outside a fill is ignored.
    spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("spurious_ignored", fill_data_valid, 0);
    end

    // Reset after seven returns abandons fill and buffered stores.
    do_fill(32'h0000_0700);
    push_store(32'h900, 32'h1111_2222);
    push_store(32'h901, 32'h3333_4444);
    for (int i = 0; i < 200 && ret_seen < 7; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("t7_seven_returns", ret_seen, 7);
    @(negedge clk);
    rst = 1'b0;
    exp_wr.delete(); exp_ra.delete(); exp_fd.delete();
    fill_active = 1'b0;
    ret_seen = 0;
    #1;
    check_reset_outputs("t7_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_eq("t7_no_done", fill_done_cnt, 4);
    check_eq("t7_buffer_discarded", wbuf_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, memory word-address width.
REQ-002 SHALL have parameter WORD_WIDTH, 32, data word width.
REQ-003 SHALL have parameter WBUF_DEPTH, 4, store-buffer entries (power of 2, >=2).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: fill_req in 1 line-fill request, held until fill_ack; fill_addr in ADDR_WIDTH block word address, bits [3:0] ignored.
REQ-006 SHALL have ports: fill_ack out 1 accept pulse; fill_data out WORD_WIDTH returned word; fill_data_valid out 1; fill_done out 1 last-word pulse.
REQ-007 SHALL have ports: st_valid in 1; st_addr in ADDR_WIDTH store word address; st_data in WORD_WIDTH; st_ready out 1 buffer not full; wbuf_empty out 1.
REQ-008 SHALL have ports: memory_addr out ADDR_WIDTH; memory_write_en out 1; memory_write_data out WORD_WIDTH; memory_read_addr_valid out 1; memory_read_ready in 1; memory_read_valid in 1; memory_read_data in WORD_WIDTH.

Function
REQ-009 SHALL buffer stores in a FIFO; push on st_valid & st_ready; st_ready = !full, combinational from occupancy.
REQ-010 SHALL support simultaneous push and pop in one cycle, occupancy unchanged; push when full SHALL be impossible (st_ready low).
REQ-011 SHALL implement FSM IDLE, DRAIN, FILL; all memory-side and fill-side outputs registered.
REQ-012 IDLE: fill_req -> FILL (fill_ack high one cycle, fill_addr[ADDR_WIDTH-1:4] latched); else buffer non-empty -> DRAIN; else stay.
REQ-013 DRAIN: pops head, drives memory_addr=head addr, memory_write_data=head data, memory_write_en=1 for exactly one cycle, returns to IDLE (re-arbitrate after every word; fill wins).
REQ-014 FILL: issue counter 0..15; each cycle counter<16 and memory_read_ready, register memory_addr={latched block, counter}, memory_read_addr_valid=1, counter++; otherwise memory_read_addr_valid=0.
REQ-015 FILL: each memory_read_valid forwards memory_read_data to fill_data with fill_data_valid=1 next cycle, return counter++; 16th return also pulses fill_done and moves to IDLE.
REQ-016 memory_read_valid outside FILL SHALL be ignored; memory_write_en SHALL never be high in FILL; stores still accepted during FILL.
REQ-017 Returned words SHALL be forwarded in arrival order, assumed address order; no reordering.
REQ-018 Store accepted at edge E0 with FSM IDLE and no fill_req SHALL produce memory_write_en in the cycle after E1.

Reset
REQ-019 SHALL on rst low: FSM=IDLE, FIFO empty, counters 0, wbuf_empty=1, st_ready=1, fill_ack/fill_data_valid/fill_done/memory_write_en/memory_read_addr_valid=0, memory_addr/memory_write_data/fill_data=0.
REQ-020 Reset mid-fill or mid-drain SHALL abandon the operation and discard buffered stores; no fill_done issued.

Configuration
REQ-021 Macro MEM_ARB_RAW_CHECK_EN defined: in IDLE, if fill_req and any valid buffer entry has st_addr[ADDR_WIDTH-1:4] equal to fill_addr[ADDR_WIDTH-1:4], SHALL go DRAIN instead of FILL, until no matching entry remains.
REQ-022 Macro undefined: fill_req SHALL always win in IDLE, no address compare logic present.

Verification
REQ-023 Store 0x100/0xDEADBEEF in IDLE -> memory_write_en=1, memory_addr=0x100, data 0xDEADBEEF one cycle, wbuf_empty=1 after.
REQ-024 Five stores back-to-back, no drain possible (fill active) -> st_ready=0 after fourth; fifth held; all drain in order after fill_done.
REQ-025 fill_req addr 0x240, memory_read_ready=1 -> 16 addresses 0x240..0x24F consecutive; 16 returns -> 16 fill_data_valid, fill_done on last.
REQ-026 memory_read_ready toggling 1/0 during fill -> addresses issued only on ready cycles, none skipped or repeated.
REQ-027 Buffer holds store 0x243, fill_req 0x240: with MEM_ARB_RAW_CHECK_EN write precedes first read address; without, reads issue first.
REQ-028 rst low after 7 fill returns -> all outputs at reset values next cycle; fill_done never asserted.
